// File: rtl/uart_rx_oversampler.sv
// 16x oversampling 8N1 UART receiver with a 4-deep received-byte history.
// Start, data and stop bits are sampled near mid-bit from a synchronized RX.
module uart_rx_oversampler #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            RX,
   output logic [3:0][7:0] RXBUF,
   output logic [7:0]      rx_data,
   output logic            rx_valid,
   output logic            frame_err,
   output logic            busy,
   output logic [2:0]      byte_count
);

   localparam int DIV = CLK_FREQ / (BAUD * 16);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
   localparam logic [DW-1:0] DIV_ONE = DW'(1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_IDLE = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [DW-1:0]   div_q, div_d;
   logic [3:0]      tick_q, tick_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            prev_q, prev_d;
   logic [7:0]      shift_q, shift_d;
   logic [3:0][7:0] rxbuf_q, rxbuf_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic [2:0]      byte_count_q, byte_count_d;
   logic            rx_valid_q, rx_valid_d;
   logic            frame_err_q, frame_err_d;

   logic rx_s;
   logic tick;

   assign rx_s = sync2_q;
   assign tick = (state_q != S_IDLE) && (div_q == DIV_MAX);

   always_comb begin
      state_d      = state_q;
      tick_d       = tick_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      rxbuf_d      = rxbuf_q;
      rx_data_d    = rx_data_q;
      byte_count_d = byte_count_q;
      rx_valid_d   = 1'b0;
      frame_err_d  = 1'b0;
      sync1_d      = RX;
      sync2_d      = sync1_q;
      prev_d       = sync2_q;

      // Divider is parked at 0 in IDLE so a new frame always starts phase-aligned.
      if (state_q == S_IDLE || tick) div_d = '0;
      else                           div_d = div_q + DIV_ONE;

      case (state_q)
         S_IDLE: begin
            if (prev_q && !rx_s) begin
               state_d = S_START;
               tick_d  = 4'd0;
            end
         end
         S_START: begin
            if (tick) begin
               if (tick_q == 4'd7) begin
                  tick_d    = 4'd0;
                  bit_idx_d = 3'd0;
                  state_d   = rx_s ? S_IDLE : S_DATA;
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (tick_q == 4'd15) begin
                  tick_d  = 4'd0;
                  shift_d = {rx_s, shift_q[7:1]};
                  if (bit_idx_q == 3'd7) state_d = S_STOP;
                  else                   bit_idx_d = bit_idx_q + 3'd1;
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               if (tick_q == 4'd15) begin
                  tick_d = 4'd0;
                  if (rx_s) begin
                     state_d    = S_IDLE;
                     rx_valid_d = 1'b1;
                     rx_data_d  = shift_q;
                     rxbuf_d    = {rxbuf_q[2:0], shift_q};
                     if (byte_count_q != 3'd4) byte_count_d = byte_count_q + 3'd1;
                  end else begin
                     state_d     = S_WAIT_IDLE;
                     frame_err_d = 1'b1;
                  end
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         div_q        <= '0;
         tick_q       <= 4'd0;
         bit_idx_q    <= 3'd0;
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         prev_q       <= 1'b1;
         shift_q      <= 8'h00;
         rxbuf_q      <= '0;
         rx_data_q    <= 8'h00;
         byte_count_q <= 3'd0;
         rx_valid_q   <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         tick_q       <= tick_d;
         bit_idx_q    <= bit_idx_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         prev_q       <= prev_d;
         shift_q      <= shift_d;
         rxbuf_q      <= rxbuf_d;
         rx_data_q    <= rx_data_d;
         byte_count_q <= byte_count_d;
         rx_valid_q   <= rx_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign RXBUF      = rxbuf_q;
   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign frame_err  = frame_err_q;
   assign byte_count = byte_count_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Randomized bench for uart_rx_oversampler against a queue-based history model.
module tb_uart_rx_oversampler;

   localparam int CF  = 1_600_000;
   localparam int BD  = 10_000;
   localparam int BIT = CF / BD;          // 160 clocks per bit
   localparam int LAT = BIT * 19 / 2 + 3; // 9.5 bits + 2 sync flops + 1 clock

   typedef logic [3:0][7:0] buf_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       RX = 1'b1;
   buf_t       RXBUF;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, busy;
   logic [2:0] byte_count;

   uart_rx_oversampler #(.CLK_FREQ(CF), .BAUD(BD)) dut (
      .clk(clk), .reset(reset), .RX(RX), .RXBUF(RXBUF), .rx_data(rx_data),
      .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy), .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nfail = 0;

   // Monitor: logs every output pulse and any output change outside an accept or reset.
   int unsigned cyc = 0;
   logic        rst_s = 1'b1;
   logic [7:0]  got_log[$];
   int unsigned valid_cyc = 0;
   int          fe_cnt = 0;
   int          overlap = 0;
   int          spurious = 0;
   buf_t        prev_buf;
   logic [7:0]  prev_data;
   logic [2:0]  prev_cnt;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_s <= reset;
   end

   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         got_log.push_back(rx_data);
         valid_cyc <= cyc;
      end
      if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
      if (rx_valid === 1'b1 && frame_err === 1'b1) overlap <= overlap + 1;
      if (rx_valid !== 1'b1 && !rst_s &&
          (RXBUF !== prev_buf || rx_data !== prev_data || byte_count !== prev_cnt))
         spurious <= spurious + 1;
      prev_buf  <= RXBUF;
      prev_data <= rx_data;
      prev_cnt  <= byte_count;
   end

   // Reference model: history of accepted bytes, newest first, at most four kept.
   logic [7:0] m_hist[$];
   logic [7:0] m_data = 8'h00;
   int unsigned fall_cyc = 0;

   function automatic void model_reset();
      m_hist.delete();
      m_data = 8'h00;
   endfunction

   function automatic void model_accept(input logic [7:0] b);
      m_hist.push_front(b);
      if (m_hist.size() > 4) void'(m_hist.pop_back());
      m_data = b;
   endfunction

   function automatic buf_t exp_buf();
      buf_t r = '0;
      for (int i = 0; i < 4; i++) if (i < m_hist.size()) r[i] = m_hist[i];
      return r;
   endfunction

   function automatic logic [2:0] exp_cnt();
      return 3'(m_hist.size());
   endfunction

   task automatic hold(input logic v, input int n);
      RX = v;
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
      fall_cyc = cyc;
      hold(1'b0, BIT);
      for (int i = 0; i < 8; i++) hold(b[i], BIT);
      if (stop_low_bits > 0) hold(1'b0, stop_low_bits * BIT);
      hold(1'b1, BIT);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      hold(1'b1, 4);
      reset = 1'b0;
      hold(1'b1, 4);
      model_reset();
      nvec++; if (RXBUF !== exp_buf()) begin nfail++; $display("FAIL reset_rxbuf: got %h expected %h", RXBUF, exp_buf()); end
      nvec++; if (rx_data !== 8'h00) begin nfail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
      nvec++; if (byte_count !== 3'd0) begin nfail++; $display("FAIL reset_count: got %0d expected 0", byte_count); end
      nvec++; if ({rx_valid, frame_err, busy} !== 3'b000) begin nfail++; $display("FAIL reset_flags: got %b expected 000", {rx_valid, frame_err, busy}); end
   endtask

   task automatic test_single();
      int n0 = got_log.size();
      int f0 = fe_cnt;
      send_frame(8'hA5, 0);
      model_accept(8'hA5);
      hold(1'b1, 20);
      nvec++; if (got_log.size() - n0 !== 1) begin nfail++; $display("FAIL single_pulses: got %0d expected 1", got_log.size() - n0); end
      nvec++; if (rx_data !== 8'hA5) begin nfail++; $display("FAIL single_data: got %h expected a5", rx_data); end
      nvec++; if (RXBUF !== exp_buf()) begin nfail++; $display("FAIL single_rxbuf: got %h expected %h", RXBUF, exp_buf()); end
      nvec++; if (byte_count !== exp_cnt()) begin nfail++; $display("FAIL single_count: got %0d expected %0d", byte_count, exp_cnt()); end
      nvec++; if (fe_cnt !== f0) begin nfail++; $display("FAIL single_fe: got %0d expected %0d", fe_cnt - f0, 0); end
      nvec++; if (valid_cyc - fall_cyc !== LAT) begin nfail++; $display("FAIL single_latency: got %0d expected %0d", valid_cyc - fall_cyc, LAT); end
   endtask

   task automatic test_back_to_back();
      int n0 = got_log.size();
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 0);
         model_accept(8'(i));
      end
      hold(1'b1, 20);
      nvec++; if (got_log.size() - n0 !== 5) begin nfail++; $display("FAIL b2b_pulses: got %0d expected 5", got_log.size() - n0); end
      for (int i = 0; i < 5 && n0 + i < got_log.size(); i++) begin
         nvec++; if (got_log[n0 + i] !== 8'(i + 1)) begin nfail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got_log[n0 + i], 8'(i + 1)); end
      end
      nvec++; if (RXBUF !== 32'h02030405) begin nfail++; $display("FAIL b2b_rxbuf: got %h expected 02030405", RXBUF); end
      nvec++; if (byte_count !== 3'd4) begin nfail++; $display("FAIL b2b_count: got %0d expected 4", byte_count); end
   endtask

   task automatic test_glitch();
      int n0 = got_log.size();
      int f0 = fe_cnt;
      int waited = 0;
      hold(1'b0, 40);
      hold(1'b1, 20);
      nvec++; if (busy !== 1'b1) begin nfail++; $display("FAIL glitch_busy_hi: got %b expected 1", busy); end
      while (busy !== 1'b0 && waited < 400) begin
         hold(1'b1, 1);
         waited++;
      end
      nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL glitch_busy_fall: got %b expected 0 after %0d clk", busy, waited); end
      hold(1'b1, 2 * BIT);
      nvec++; if (got_log.size() !== n0 || fe_cnt !== f0) begin nfail++; $display("FAIL glitch_pulses: got %0d valid %0d ferr expected 0 0", got_log.size() - n0, fe_cnt - f0); end
      nvec++; if (RXBUF !== exp_buf()) begin nfail++; $display("FAIL glitch_rxbuf: got %h expected %h", RXBUF, exp_buf()); end
   endtask

   task automatic test_frame_err();
      int n0 = got_log.size();
      int f0 = fe_cnt;
      send_frame(8'h3C, 2);
      hold(1'b1, 20);
      nvec++; if (fe_cnt - f0 !== 1) begin nfail++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - f0); end
      nvec++; if (got_log.size() !== n0) begin nfail++; $display("FAIL ferr_valid: got %0d expected 0", got_log.size() - n0); end
      nvec++; if (RXBUF !== exp_buf()) begin nfail++; $display("FAIL ferr_rxbuf: got %h expected %h", RXBUF, exp_buf()); end
      send_frame(8'h77, 0);
      model_accept(8'h77);
      hold(1'b1, 20);
      nvec++; if (rx_data !== 8'h77) begin nfail++; $display("FAIL ferr_next_data: got %h expected 77", rx_data); end
      nvec++; if (RXBUF !== exp_buf()) begin nfail++; $display("FAIL ferr_next_rxbuf: got %h expected %h", RXBUF, exp_buf()); end
   endtask

   task automatic test_reset_mid();
      int n0 = got_log.size();
      int f0 = fe_cnt;
      hold(1'b0, BIT);
      for (int i = 0; i < 4; i++) hold(1'b1, BIT);
      hold(1'b1, BIT / 2);
      reset = 1'b1;
      hold(1'b1, 1);
      reset = 1'b0;
      model_reset();
      hold(1'b1, BIT / 2 + 4 * BIT);
      nvec++; if (got_log.size() !== n0 || fe_cnt !== f0) begin nfail++; $display("FAIL rstmid_pulses: got %0d valid %0d ferr expected 0 0", got_log.size() - n0, fe_cnt - f0); end
      nvec++; if ({RXBUF, rx_data, byte_count, busy} !== '0) begin nfail++; $display("FAIL rstmid_outputs: got %h %h %0d %b expected all zero", RXBUF, rx_data, byte_count, busy); end
      send_frame(8'h5A, 0);
      model_accept(8'h5A);
      hold(1'b1, 20);
      nvec++; if (rx_data !== 8'h5A) begin nfail++; $display("FAIL rstmid_next_data: got %h expected 5a", rx_data); end
      nvec++; if (byte_count !== exp_cnt()) begin nfail++; $display("FAIL rstmid_next_count: got %0d expected %0d", byte_count, exp_cnt()); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) begin
         logic [7:0] b = 8'($urandom_range(0, 255));
         bit bad = ($urandom_range(0, 4) == 0);
         int n0 = got_log.size();
         int f0 = fe_cnt;
         send_frame(b, bad ? 1 : 0);
         if (!bad) model_accept(b);
         hold(1'b1, 8);
         if (bad) begin
            nvec++; if (fe_cnt - f0 !== 1 || got_log.size() !== n0) begin nfail++; $display("FAIL rand%0d_ferr: got %0d ferr %0d valid expected 1 0", k, fe_cnt - f0, got_log.size() - n0); end
         end else begin
            nvec++; if (got_log.size() - n0 !== 1 || rx_data !== b) begin nfail++; $display("FAIL rand%0d_data: got %h (%0d pulses) expected %h", k, rx_data, got_log.size() - n0, b); end
         end
         nvec++; if (RXBUF !== exp_buf() || byte_count !== exp_cnt()) begin nfail++; $display("FAIL rand%0d_hist: got %h/%0d expected %h/%0d", k, RXBUF, byte_count, exp_buf(), exp_cnt()); end
         hold(1'b1, $urandom_range(0, 1) * $urandom_range(1, 300));
      end
   endtask

   task automatic test_invariants();
      nvec++; if (overlap !== 0) begin nfail++; $display("FAIL overlap: got %0d cycles expected 0", overlap); end
      nvec++; if (spurious !== 0) begin nfail++; $display("FAIL stability: got %0d changes expected 0", spurious); end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_mid();
      test_random();
      test_invariants();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
